// File: rtl/rv_data_arbiter.sv
// Two-master arbiter for the shared core data-memory port.
// An in-order ID FIFO sends each memory response back to the master that issued it.
module rv_data_arbiter #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int PRIORITY_RR = 1
) (
    input  logic              clk_i,
    input  logic              arstn_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,

    output logic              data_req_o,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i,

    output logic              err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic          RR_MODE   = (PRIORITY_RR != 0);

    logic [DEPTH-1:0] fifo_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             last_gnt_q;
    logic             err_q;

    logic has_out;
    logic pop;
    logic can_issue;
    logic gnt0;
    logic gnt1;
    logic push;
    logic head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign has_out   = (count_q != '0);
    assign pop       = data_rvalid_i & has_out;
    // A response retiring this cycle frees its slot for a same-cycle issue.
    assign can_issue = (count_q < DEPTH_C) | pop;
    assign head      = fifo_q[rd_ptr_q];

    // Round-robin tie goes to the master that did not win last; fixed mode favours master 0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_issue) begin
            if (m0_req_i && m1_req_i) begin
                if (RR_MODE && !last_gnt_q) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign push     = gnt0 | gnt1;
    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    assign data_req_o   = push;
    assign data_we_o    = gnt1 ? m1_we_i    : m0_we_i;
    assign data_be_o    = gnt1 ? m1_be_i    : m0_be_i;
    assign data_addr_o  = gnt1 ? m1_addr_i  : m0_addr_i;
    assign data_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;

    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop &  head;
    assign m0_rdata_o  = data_rdata_i;
    assign m1_rdata_o  = data_rdata_i;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= gnt1;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                last_gnt_q       <= gnt1;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (data_rvalid_i && !has_out) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_data_arbiter.sv
// Directed bench for rv_data_arbiter: a round-robin and a fixed-priority instance share stimulus.
// A per-cycle vector table covers arbitration, back-pressure and spurious responses; hand sequences cover payload muxing and reset.
module tb_rv_data_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            arstn;
    logic            m0_req, m0_we, m1_req, m1_we;
    logic [3:0]      m0_be, m1_be;
    logic [31:0]     m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic            rvalid;
    logic [31:0]     rdata;

    logic            r_gnt0, r_gnt1, r_rv0, r_rv1, r_req, r_we, r_err;
    logic [3:0]      r_be;
    logic [31:0]     r_rd0, r_rd1, r_addr, r_wdata;
    logic            f_gnt0, f_gnt1, f_rv0, f_rv1, f_req, f_we, f_err;
    logic [3:0]      f_be;
    logic [31:0]     f_rd0, f_rd1, f_addr, f_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_data_arbiter #(.XLEN(XLEN), .DEPTH(2), .PRIORITY_RR(1)) u_rr (
        .clk_i(clk), .arstn_i(arstn),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(r_gnt0), .m0_rvalid_o(r_rv0), .m0_rdata_o(r_rd0),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(r_gnt1), .m1_rvalid_o(r_rv1), .m1_rdata_o(r_rd1),
        .data_req_o(r_req), .data_we_o(r_we), .data_be_o(r_be), .data_addr_o(r_addr), .data_wdata_o(r_wdata),
        .data_rvalid_i(rvalid), .data_rdata_i(rdata), .err_o(r_err)
    );

    rv_data_arbiter #(.XLEN(XLEN), .DEPTH(2), .PRIORITY_RR(0)) u_fp (
        .clk_i(clk), .arstn_i(arstn),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(f_gnt0), .m0_rvalid_o(f_rv0), .m0_rdata_o(f_rd0),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(f_gnt1), .m1_rvalid_o(f_rv1), .m1_rdata_o(f_rd1),
        .data_req_o(f_req), .data_we_o(f_we), .data_be_o(f_be), .data_addr_o(f_addr), .data_wdata_o(f_wdata),
        .data_rvalid_i(rvalid), .data_rdata_i(rdata), .err_o(f_err)
    );

    typedef struct {
        logic        do_rst;
        logic        m0_req;
        logic        m1_req;
        logic        rv;
        logic [31:0] rdata;
        logic        gnt0;
        logic        gnt1;
        logic        req;
        logic        rv0;
        logic        rv1;
        logic [31:0] addr;
        logic        err;
        logic        fgnt0;
        logic        fgnt1;
        logic        frv0;
        logic        frv1;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; rvalid = 1'b0; rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arstn = 1'b0;
        #2;
        arstn = 1'b1;
    endtask

    initial begin
        // do_rst m0 m1 rv rdata        | gnt0 gnt1 req rv0 rv1 addr         err | fp gnt0 gnt1 rv0 rv1
        vecs[0]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h100, 0,  0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h100, 0,  1, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 32'h100, 0,  0, 0, 1, 0};
        vecs[3]  = '{1, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h100, 0,  1, 0, 0, 0};
        vecs[4]  = '{0, 1, 1, 1, 32'hA1,       0, 1, 1, 1, 0, 32'h300, 0,  1, 0, 1, 0};
        vecs[5]  = '{0, 1, 1, 1, 32'hA2,       1, 0, 1, 0, 1, 32'h100, 0,  1, 0, 1, 0};
        vecs[6]  = '{0, 1, 1, 1, 32'hA3,       0, 1, 1, 1, 0, 32'h300, 0,  1, 0, 1, 0};
        vecs[7]  = '{0, 0, 0, 1, 32'hA4,       0, 0, 0, 0, 1, 32'h100, 0,  0, 0, 1, 0};
        vecs[8]  = '{0, 0, 1, 0, 32'h0,        0, 1, 1, 0, 0, 32'h300, 0,  0, 1, 0, 0};
        vecs[9]  = '{0, 0, 1, 0, 32'h0,        0, 1, 1, 0, 0, 32'h300, 0,  0, 1, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h100, 0,  0, 0, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h100, 0,  0, 0, 0, 0};
        vecs[12] = '{0, 0, 1, 1, 32'hB1,       0, 1, 1, 0, 1, 32'h300, 0,  0, 1, 0, 1};
        vecs[13] = '{0, 0, 0, 1, 32'hB2,       0, 0, 0, 0, 1, 32'h100, 0,  0, 0, 0, 1};
        vecs[14] = '{0, 0, 0, 1, 32'hB3,       0, 0, 0, 0, 1, 32'h100, 0,  0, 0, 0, 1};
        vecs[15] = '{0, 0, 0, 1, 32'hB4,       0, 0, 0, 0, 0, 32'h100, 0,  0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h100, 1,  0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h100, 1,  0, 0, 0, 0};

        idle_inputs();
        m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h100; m0_wdata = 32'h0;
        m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h300; m1_wdata = 32'hAA;
        arstn = 1'b0;
        #12;
        arstn = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].do_rst) do_reset();
            m0_req = vecs[i].m0_req;
            m1_req = vecs[i].m1_req;
            rvalid = vecs[i].rv;
            rdata  = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d rr_gnt0", i),   32'(r_gnt0), 32'(vecs[i].gnt0));
            chk($sformatf("v%0d rr_gnt1", i),   32'(r_gnt1), 32'(vecs[i].gnt1));
            chk($sformatf("v%0d rr_req", i),    32'(r_req),  32'(vecs[i].req));
            chk($sformatf("v%0d rr_rv0", i),    32'(r_rv0),  32'(vecs[i].rv0));
            chk($sformatf("v%0d rr_rv1", i),    32'(r_rv1),  32'(vecs[i].rv1));
            chk($sformatf("v%0d rr_addr", i),   r_addr,      vecs[i].addr);
            chk($sformatf("v%0d rr_err", i),    32'(r_err),  32'(vecs[i].err));
            chk($sformatf("v%0d rr_rdata0", i), r_rd0,       vecs[i].rdata);
            chk($sformatf("v%0d rr_rdata1", i), r_rd1,       vecs[i].rdata);
            chk($sformatf("v%0d fp_gnt0", i),   32'(f_gnt0), 32'(vecs[i].fgnt0));
            chk($sformatf("v%0d fp_gnt1", i),   32'(f_gnt1), 32'(vecs[i].fgnt1));
            chk($sformatf("v%0d fp_rv0", i),    32'(f_rv0),  32'(vecs[i].frv0));
            chk($sformatf("v%0d fp_rv1", i),    32'(f_rv1),  32'(vecs[i].frv1));
            chk($sformatf("v%0d fp_err", i),    32'(f_err),  32'(vecs[i].err));
            tick();
        end

        // Write from m0 then read from m1; responses 3 and 4 cycles after issue.
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'b0011; m0_addr = 32'h200; m0_wdata = 32'h12345678;
        @(negedge clk);
        chk("wr gnt0",  32'(r_gnt0), 32'd1);
        chk("wr req",   32'(r_req),  32'd1);
        chk("wr we",    32'(r_we),   32'd1);
        chk("wr be",    32'(r_be),   32'h3);
        chk("wr addr",  r_addr,      32'h200);
        chk("wr wdata", r_wdata,     32'h12345678);
        tick();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h300;
        @(negedge clk);
        chk("rd gnt1", 32'(r_gnt1), 32'd1);
        chk("rd gnt0", 32'(r_gnt0), 32'd0);
        chk("rd we",   32'(r_we),   32'd0);
        chk("rd addr", r_addr,      32'h300);
        tick();
        m1_req = 1'b0;
        @(negedge clk);
        chk("gap rv0", 32'(r_rv0), 32'd0);
        chk("gap rv1", 32'(r_rv1), 32'd0);
        tick();
        rvalid = 1'b1; rdata = 32'h0;
        @(negedge clk);
        chk("resp1 rv0", 32'(r_rv0), 32'd1);
        chk("resp1 rv1", 32'(r_rv1), 32'd0);
        tick();
        rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("resp2 rv0",   32'(r_rv0), 32'd0);
        chk("resp2 rv1",   32'(r_rv1), 32'd1);
        chk("resp2 rdata", r_rd1,      32'hCAFEF00D);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("post err", 32'(r_err), 32'd0);
        tick();

        // Sticky error, then reset with two transactions outstanding.
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        m0_addr = 32'h100;
        m0_req = 1'b1;
        @(negedge clk);
        chk("sticky err", 32'(r_err),  32'd1);
        chk("refill gnt", 32'(r_gnt0), 32'd1);
        tick();
        @(negedge clk);
        chk("refill gnt2", 32'(r_gnt0), 32'd1);
        tick();
        do_reset();
        @(negedge clk);
        chk("rst err",  32'(r_err), 32'd0);
        chk("rst rv0",  32'(r_rv0), 32'd0);
        chk("rst req",  32'(r_req), 32'd0);
        tick();
        rvalid = 1'b1; rdata = 32'h55;
        @(negedge clk);
        chk("late rv0", 32'(r_rv0), 32'd0);
        chk("late rv1", 32'(r_rv1), 32'd0);
        chk("late err same cycle", 32'(r_err), 32'd0);
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("late err", 32'(r_err), 32'd1);
        chk("late fp err", 32'(f_err), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
